// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants for the 5-stage MIPS core: Tuse/Tnew encodings,
// the hardwired zero register and the HI/LO unit latencies.
package cpu_pipe_pkg;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;
  localparam logic [1:0] TNEW_3 = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/hazard_stall_ctrl_chk.sv
// Simulation-only checker: flags a mult/div issue while HI/LO is still busy.
module md_busy_chk #(
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             md_start_e,
  input logic [CNT_W-1:0] md_cnt
);

  // Issuing into a busy unit is illegal; the counter still reloads.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(md_start_e && (md_cnt != {CNT_W{1'b0}}))
  );

endmodule

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// HI/LO occupancy tracker: loads the op latency on issue, counts down to idle.
module md_busy_counter
  import cpu_pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start_e,
  input  logic             md_is_div_e,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  logic [CNT_W-1:0] md_cnt_d, md_cnt_q;

  // Next count: reload on issue (even if illegal), else decrement to zero.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_e) begin
      md_cnt_d = md_is_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (md_cnt_q != {CNT_W{1'b0}}) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end else begin
      md_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Count register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q <= {CNT_W{1'b0}};
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != {CNT_W{1'b0}}) | md_start_e;
  assign md_cnt  = md_cnt_q;

  md_busy_chk #(.CNT_W(CNT_W)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .md_start_e (md_start_e),
    .md_cnt     (md_cnt_q)
  );

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: data/HI-LO stall detection and IF/ID flush that
// survives a concurrent stall via a pending-flush register.
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] wreg_e,
  input  logic [1:0] tnew_e,
  input  logic [4:0] wreg_m,
  input  logic [1:0] tnew_m,
  input  logic       md_use_d,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  input  logic       flush_req,
  output logic       pc_en,
  output logic       endd,
  output logic       flushd,
  output logic       flush_e,
  output logic       md_busy
);

  logic             stall_rs_s, stall_rt_s, md_stall_s, stall_s;
  logic             flushd_s;
  logic             flush_pend_d, flush_pend_q;
  logic [CNT_W-1:0] md_cnt_s;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_cnt (
    .clk         (clk),
    .reset       (reset),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .md_busy     (md_busy),
    .md_cnt      (md_cnt_s)
  );

  // A source stalls when a producer still needs longer than the consumer can wait.
  always_comb begin
    stall_rs_s = (rs_d != REG_ZERO) &
                 (((rs_d == wreg_e) & (tnew_e > tuse_rs_d)) |
                  ((rs_d == wreg_m) & (tnew_m > tuse_rs_d)));
    stall_rt_s = (rt_d != REG_ZERO) &
                 (((rt_d == wreg_e) & (tnew_e > tuse_rt_d)) |
                  ((rt_d == wreg_m) & (tnew_m > tuse_rt_d)));
    md_stall_s = md_use_d & md_busy;
    stall_s    = stall_rs_s | stall_rt_s | md_stall_s;
    flushd_s   = (flush_req | flush_pend_q) & ~stall_s;
  end

  // A flush blocked by endd is parked until the stall lifts.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flushd_s) begin
      flush_pend_d = 1'b0;
    end else if (flush_req & stall_s) begin
      flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = flush_pend_q;
    end
  end

  // Pending-flush register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end

  assign endd    = stall_s;
  assign pc_en   = ~stall_s;
  assign flush_e = stall_s;
  assign flushd  = flushd_s;

  // md_cnt_s is only observed by the counter's own checker.
  logic unused_s;
  assign unused_s = ^md_cnt_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed scenarios then constrained-random traffic
// against a cycle-level behavioural model of the sequencer.
module tb_hazard_stall_ctrl;
  import cpu_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, wreg_e, wreg_m;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic       md_use_d, md_start_e, md_is_div_e, flush_req;
  logic       pc_en, endd, flushd, flush_e, md_busy;

  int checks   = 0;
  int failures = 0;
  int m_rem    = 0;   // model: cycles HI/LO remains busy after this edge
  bit m_pend   = 1'b0;
  int n_hold;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .tuse_rs_d   (tuse_rs_d),
    .tuse_rt_d   (tuse_rt_d),
    .wreg_e      (wreg_e),
    .tnew_e      (tnew_e),
    .wreg_m      (wreg_m),
    .tnew_m      (tnew_m),
    .md_use_d    (md_use_d),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .flush_req   (flush_req),
    .pc_en       (pc_en),
    .endd        (endd),
    .flushd      (flushd),
    .flush_e     (flush_e),
    .md_busy     (md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit src_waits(logic [4:0] r, logic [1:0] tuse);
    int need, ready_e, ready_m;
    if (r == 5'd0) return 1'b0;
    need    = int'(tuse);
    ready_e = (r == wreg_e) ? int'(tnew_e) : 0;
    ready_m = (r == wreg_m) ? int'(tnew_m) : 0;
    return (ready_e > need) || (ready_m > need);
  endfunction

  function automatic bit ref_busy();
    return (m_rem > 0) || md_start_e;
  endfunction

  function automatic bit ref_stall();
    return src_waits(rs_d, tuse_rs_d) || src_waits(rt_d, tuse_rt_d) ||
           (md_use_d && ref_busy());
  endfunction

  task automatic check_outputs(string tag);
    bit s, f;
    s = ref_stall();
    f = (flush_req || m_pend) && !s;
    check({tag, ".pc_en"},   32'(pc_en),   32'(!s));
    check({tag, ".endd"},    32'(endd),    32'(s));
    check({tag, ".flush_e"}, 32'(flush_e), 32'(s));
    check({tag, ".flushd"},  32'(flushd),  32'(f));
    check({tag, ".md_busy"}, 32'(md_busy), 32'(ref_busy()));
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic step(string tag);
    bit s, f;
    @(negedge clk);
    check_outputs(tag);
    s = ref_stall();
    f = (flush_req || m_pend) && !s;
    @(posedge clk);
    if (md_start_e)     m_rem = md_is_div_e ? DIV_CYC_DEF : MULT_CYC_DEF;
    else if (m_rem > 0) m_rem = m_rem - 1;
    if (f)                   m_pend = 1'b0;
    else if (flush_req && s) m_pend = 1'b1;
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = 5'd0; rt_d = 5'd0; wreg_e = 5'd0; wreg_m = 5'd0;
    tuse_rs_d = TUSE_NONE; tuse_rt_d = TUSE_NONE; tnew_e = TNEW_0; tnew_m = TNEW_0;
    md_use_d = 1'b0; md_start_e = 1'b0; md_is_div_e = 1'b0; flush_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #12;
    check("rst.pc_en",   32'(pc_en),   32'd1);
    check("rst.endd",    32'(endd),    32'd0);
    check("rst.flushd",  32'(flushd),  32'd0);
    check("rst.flush_e", 32'(flush_e), 32'd0);
    check("rst.md_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    step("idle");

    // Load-use on rs, then the same E state with rs = $0.
    wreg_e = 5'd5; tnew_e = TNEW_2; rs_d = 5'd5; tuse_rs_d = TUSE_1;
    #1;
    check("lu.endd",    32'(endd),    32'd1);
    check("lu.pc_en",   32'(pc_en),   32'd0);
    check("lu.flush_e", 32'(flush_e), 32'd1);
    step("lu");
    rs_d = 5'd0;
    #1;
    check("lu_r0.endd", 32'(endd), 32'd0);
    step("lu_r0");
    rt_d = 5'd5; tuse_rt_d = TUSE_2;
    step("lu_rt_enough");
    wreg_m = 5'd7; tnew_m = TNEW_1; rt_d = 5'd7; tuse_rt_d = TUSE_0;
    step("m_hazard_rt");
    clear_inputs();

    // Divide: issue, then a HI/LO user held in D.
    md_start_e = 1'b1; md_is_div_e = 1'b1;
    #1;
    check("div.issue_busy", 32'(md_busy), 32'd1);
    step("div_issue");
    md_start_e = 1'b0; md_is_div_e = 1'b0; md_use_d = 1'b1;
    n_hold = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (endd) n_hold++;
      step("div_hold");
    end
    check("div.len", 32'(n_hold), 32'd10);
    clear_inputs();

    // Multiply.
    md_start_e = 1'b1;
    step("mul_issue");
    md_start_e = 1'b0; md_use_d = 1'b1;
    n_hold = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (endd) n_hold++;
      step("mul_hold");
    end
    check("mul.len", 32'(n_hold), 32'd5);
    clear_inputs();

    // Flush during a 2-cycle load-use stall.
    wreg_e = 5'd9; tnew_e = TNEW_2; rs_d = 5'd9; tuse_rs_d = TUSE_1; flush_req = 1'b1;
    #1;
    check("fl.stall0", 32'(flushd), 32'd0);
    step("fl_a");
    flush_req = 1'b0;
    #1;
    check("fl.stall1", 32'(flushd), 32'd0);
    step("fl_b");
    clear_inputs();
    #1;
    check("fl.release", 32'(flushd), 32'd1);
    step("fl_c");
    check("fl.after", 32'(flushd), 32'd0);
    step("fl_d");
    flush_req = 1'b1;
    #1;
    check("fl.direct", 32'(flushd), 32'd1);
    step("fl_direct");
    clear_inputs();

    // Reset in the middle of a divide.
    md_start_e = 1'b1; md_is_div_e = 1'b1;
    step("rd_issue");
    clear_inputs();
    for (int i = 0; i < 6; i++) step("rd_count");
    #2;
    reset = 1'b0;
    #1;
    check("rd.busy_async", 32'(md_busy), 32'd0);
    m_rem = 0; m_pend = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    md_use_d = 1'b1;
    #1;
    check("rd.no_stall", 32'(endd), 32'd0);
    step("rd_after");
    clear_inputs();

    // Constrained-random traffic; never issues into a busy unit.
    for (int i = 0; i < 400; i++) begin
      rs_d      = 5'($urandom_range(0, 3));
      rt_d      = 5'($urandom_range(0, 3));
      wreg_e    = 5'($urandom_range(0, 3));
      wreg_m    = 5'($urandom_range(0, 3));
      tuse_rs_d = 2'($urandom_range(0, 3));
      tuse_rt_d = 2'($urandom_range(0, 3));
      tnew_e    = 2'($urandom_range(0, 3));
      tnew_m    = 2'($urandom_range(0, 2));
      md_use_d  = ($urandom_range(0, 2) == 0);
      md_start_e  = (m_rem == 0) && ($urandom_range(0, 5) == 0);
      md_is_div_e = 1'($urandom_range(0, 1));
      flush_req   = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
